vector_store_seq: RTL and testbench
===================================

VECTOR_STORE_SEQ -- requirements
Module: vector_store_seq

Interface
REQ-001 SHALL have parameter ADDR_STRIDE, default 4: byte increment between consecutive lane addresses.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to store one vector; sampled only in IDLE.
REQ-005 SHALL have port base_addr  input  32  byte address of lane 0.
REQ-006 SHALL have ports result_0..result_4  input  32 each  lane results from the vector ALU stage.
REQ-007 SHALL have port mem_ready  input  1  memory accepts the current write this cycle.
REQ-008 SHALL have port MemWrite  output  1  write strobe to data memory.
REQ-009 SHALL have port DataAdr  output  32  write byte address.
REQ-010 SHALL have port WriteData  output  32  write data.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, WRITE, DONE.
REQ-014 In IDLE with start=1, SHALL capture result_0..result_4 and base_addr into internal registers, set lane index to 0, and go to WRITE.
REQ-015 In WRITE, SHALL drive MemWrite=1, DataAdr=base+idx*ADDR_STRIDE (modulo 2^32, wrap-around allowed), WriteData=captured lane[idx].
REQ-016 A write SHALL complete only in a cycle where MemWrite=1 and mem_ready=1; otherwise outputs SHALL hold unchanged.
REQ-017 On a completed write, SHALL advance to the next lane; after lane 4 completes, SHALL go to DONE.
REQ-018 In DONE, SHALL assert done=1 for exactly one cycle, MemWrite=0, then go to IDLE.
REQ-019 start SHALL be ignored in WRITE and DONE; input lane changes after capture SHALL NOT affect written data.
REQ-020 With mem_ready held 1 and start at edge T: writes occur in cycles T+1..T+5, done in T+6, and the next start is accepted at edge T+7.
REQ-021 In IDLE, MemWrite=0 and done=0; DataAdr and WriteData SHALL be 0.

Reset
REQ-022 On reset=1 at a clock edge, SHALL go to IDLE, clear lane index, captured registers, and all outputs (MemWrite=0, busy=0, done=0, DataAdr=0, WriteData=0).
REQ-023 Reset mid-operation SHALL abort with no further writes; reset takes priority over start.

Configuration
REQ-024 Macro VSTORE_LANE_MASK_EN SHALL, when defined, add input lane_mask (5 bits), captured with start.
REQ-025 With VSTORE_LANE_MASK_EN, lanes whose mask bit is 0 SHALL be skipped with no write cycle; addresses of written lanes SHALL still use their own lane index; mask=0 SHALL go from IDLE directly to DONE.
REQ-026 Without VSTORE_LANE_MASK_EN, all five lanes SHALL always be written and no lane_mask port SHALL exist.

Verification
REQ-027 base=0x100, results 1,2,3,4,5, mem_ready=1, start pulse -> writes (0x100,1),(0x104,2),(0x108,3),(0x10C,4),(0x110,5) on consecutive cycles, then done for one cycle.
REQ-028 Same stimulus, mem_ready low for 3 cycles during lane 2 -> DataAdr=0x108, WriteData=3 held for 3 cycles, with no skipped or duplicated lanes.
REQ-029 base=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, 0x8.
REQ-030 reset asserted during lane 3 write -> next cycle MemWrite=0, busy=0, done never pulses; start ignored while busy and results changed after capture -> original data written.
REQ-031 With VSTORE_LANE_MASK_EN: mask=5'b10101, base=0 -> writes only to 0x0, 0x8, 0x10, then done; mask=0 -> done one cycle after start with no write.

Source files
------------

// File: rtl/vector_store_seq.sv
// Vector store sequencer: captures five lane results and writes them to memory one lane per accepted beat.
// Optional macro VSTORE_LANE_MASK_EN adds a lane_mask input that skips lanes whose mask bit is 0.
module vector_store_seq #(
  parameter int ADDR_STRIDE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] result_0,
  input  logic [31:0] result_1,
  input  logic [31:0] result_2,
  input  logic [31:0] result_3,
  input  logic [31:0] result_4,
`ifdef VSTORE_LANE_MASK_EN
  input  logic [4:0]  lane_mask,
`endif
  input  logic        mem_ready,
  output logic        MemWrite,
  output logic [31:0] DataAdr,
  output logic [31:0] WriteData,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd2} state_t;

  localparam logic [31:0] STRIDE = ADDR_STRIDE[31:0];
  localparam logic [2:0]  NO_LANE = 3'd5;

  state_t      state;
  logic [2:0]  idx;
  logic [31:0] base_q;
  logic [31:0] lane_q [5];
  logic [4:0]  mask_in;
  logic [4:0]  mask_q;
  logic [2:0]  first_lane;
  logic [2:0]  next_lane;
  logic [31:0] first_data;
  logic [31:0] next_data;

  // Lowest enabled lane at or above 'from'; NO_LANE when none remain.
  function automatic logic [2:0] find_lane(input logic [4:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = NO_LANE;
    for (int i = 4; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [31:0] lane_addr(input logic [31:0] base, input logic [2:0] lane);
    return base + ({29'd0, lane} * STRIDE);
  endfunction

`ifdef VSTORE_LANE_MASK_EN
  assign mask_in = lane_mask;
`else
  assign mask_in = 5'b11111;
  assign mask_q  = 5'b11111;
`endif

  // Lane search and data selection for the first and the following write beat.
  always_comb begin
    first_lane = find_lane(mask_in, 3'd0);
    next_lane  = find_lane(mask_q, idx + 3'd1);
    case (first_lane)
      3'd0:    first_data = result_0;
      3'd1:    first_data = result_1;
      3'd2:    first_data = result_2;
      3'd3:    first_data = result_3;
      3'd4:    first_data = result_4;
      default: first_data = 32'd0;
    endcase
    case (next_lane)
      3'd0:    next_data = lane_q[0];
      3'd1:    next_data = lane_q[1];
      3'd2:    next_data = lane_q[2];
      3'd3:    next_data = lane_q[3];
      3'd4:    next_data = lane_q[4];
      default: next_data = 32'd0;
    endcase
  end

  // Sequencer state, captured vector and registered memory-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      base_q    <= 32'd0;
      for (int i = 0; i < 5; i++) lane_q[i] <= 32'd0;
`ifdef VSTORE_LANE_MASK_EN
      mask_q    <= 5'd0;
`endif
      MemWrite  <= 1'b0;
      DataAdr   <= 32'd0;
      WriteData <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            lane_q[0] <= result_0;
            lane_q[1] <= result_1;
            lane_q[2] <= result_2;
            lane_q[3] <= result_3;
            lane_q[4] <= result_4;
`ifdef VSTORE_LANE_MASK_EN
            mask_q    <= lane_mask;
`endif
            busy      <= 1'b1;
            if (first_lane != NO_LANE) begin
              state     <= WRITE;
              idx       <= first_lane;
              MemWrite  <= 1'b1;
              DataAdr   <= lane_addr(base_addr, first_lane);
              WriteData <= first_data;
            end else begin
              state     <= DONE;
              idx       <= 3'd0;
              done      <= 1'b1;
            end
          end
        end
        WRITE: begin
          // Outputs only move on an accepted beat; a stall leaves them untouched.
          if (mem_ready) begin
            if (next_lane != NO_LANE) begin
              idx       <= next_lane;
              DataAdr   <= lane_addr(base_q, next_lane);
              WriteData <= next_data;
            end else begin
              state     <= DONE;
              idx       <= 3'd0;
              MemWrite  <= 1'b0;
              DataAdr   <= 32'd0;
              WriteData <= 32'd0;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          idx       <= 3'd0;
          MemWrite  <= 1'b0;
          DataAdr   <= 32'd0;
          WriteData <= 32'd0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_store_seq.sv
// Directed self-checking bench for vector_store_seq; covers the masked build when VSTORE_LANE_MASK_EN is defined.
module tb_vector_store_seq;

  logic        clk = 1'b0;
  logic        reset, start, mem_ready;
  logic [31:0] base_addr, result_0, result_1, result_2, result_3, result_4;
`ifdef VSTORE_LANE_MASK_EN
  logic [4:0]  lane_mask;
`endif
  logic        MemWrite, busy, done;
  logic [31:0] DataAdr, WriteData;

  int checks = 0;
  int errors = 0;

  vector_store_seq #(.ADDR_STRIDE(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .result_0(result_0), .result_1(result_1), .result_2(result_2),
    .result_3(result_3), .result_4(result_4),
`ifdef VSTORE_LANE_MASK_EN
    .lane_mask(lane_mask),
`endif
    .mem_ready(mem_ready), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {MemWrite, busy, done, DataAdr, WriteData} is compared as one vector per cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] base, input logic [31:0] r0, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [31:0] r3, input logic [31:0] r4);
    base_addr = base; result_0 = r0; result_1 = r1; result_2 = r2; result_3 = r3; result_4 = r4;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; mem_ready = 1'b1;
    load(32'h100, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    tick();
    tick();
    checks++;
    if ({MemWrite, busy, done, DataAdr, WriteData} !== {1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state got mw=%b busy=%b done=%b adr=%h data=%h want all zero",
               MemWrite, busy, done, DataAdr, WriteData);
    end
    start = 1'b0; reset = 1'b0;
    tick();
    checks++;
    if ({MemWrite, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset got mw=%b busy=%b done=%b want 000", MemWrite, busy, done);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_adr [5];
    exp_adr = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    load(32'h100, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    start = 1'b1; mem_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({MemWrite, busy, done, DataAdr, WriteData} !== {1'b1, 1'b1, 1'b0, exp_adr[k], 32'(k + 1)}) begin
        errors++;
        $display("FAIL basic_lane%0d got mw=%b busy=%b done=%b adr=%h data=%h want 1 1 0 %h %h",
                 k, MemWrite, busy, done, DataAdr, WriteData, exp_adr[k], 32'(k + 1));
      end
      tick();
    end
    checks++;
    if ({MemWrite, busy, done, DataAdr, WriteData} !== {1'b0, 1'b1, 1'b1, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL basic_done got mw=%b busy=%b done=%b adr=%h data=%h want 0 1 1 0 0",
               MemWrite, busy, done, DataAdr, WriteData);
    end
    tick();
    checks++;
    if ({MemWrite, busy, done, DataAdr, WriteData} !== {1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL basic_idle got mw=%b busy=%b done=%b adr=%h data=%h want all zero",
               MemWrite, busy, done, DataAdr, WriteData);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_adr [8];
    logic [31:0] exp_dat [8];
    logic        rdy [8];
    exp_adr = '{32'h100, 32'h104, 32'h108, 32'h108, 32'h108, 32'h108, 32'h10C, 32'h110};
    exp_dat = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3, 32'd3, 32'd4, 32'd5};
    rdy     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    load(32'h100, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    start = 1'b1; mem_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mem_ready = rdy[k];
      checks++;
      if ({MemWrite, done, DataAdr, WriteData} !== {1'b1, 1'b0, exp_adr[k], exp_dat[k]}) begin
        errors++;
        $display("FAIL stall_cycle%0d got mw=%b done=%b adr=%h data=%h want 1 0 %h %h",
                 k, MemWrite, done, DataAdr, WriteData, exp_adr[k], exp_dat[k]);
      end
      tick();
    end
    checks++;
    if ({MemWrite, done} !== 2'b01) begin
      errors++;
      $display("FAIL stall_done got mw=%b done=%b want 0 1", MemWrite, done);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_adr [5];
    exp_adr = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4, 32'h8};
    load(32'hFFFFFFF8, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
    start = 1'b1; mem_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({MemWrite, DataAdr, WriteData} !== {1'b1, exp_adr[k], 32'hA0 + 32'(k)}) begin
        errors++;
        $display("FAIL wrap_lane%0d got mw=%b adr=%h data=%h want 1 %h %h",
                 k, MemWrite, DataAdr, WriteData, exp_adr[k], 32'hA0 + 32'(k));
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset_mid();
    load(32'h100, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    start = 1'b1; mem_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({MemWrite, DataAdr} !== {1'b1, 32'h10C}) begin
      errors++;
      $display("FAIL abort_lane3 got mw=%b adr=%h want 1 0000010c", MemWrite, DataAdr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({MemWrite, busy, done, DataAdr, WriteData} !== {1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
        errors++;
        $display("FAIL abort_cycle%0d got mw=%b busy=%b done=%b adr=%h data=%h want all zero",
                 k, MemWrite, busy, done, DataAdr, WriteData);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    load(32'h200, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55);
    start = 1'b1; mem_ready = 1'b1;
    tick();
    load(32'h900, 32'hDEAD0, 32'hDEAD1, 32'hDEAD2, 32'hDEAD3, 32'hDEAD4);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({MemWrite, DataAdr, WriteData} !== {1'b1, 32'h200 + 32'(4 * k), 32'h11 * 32'(k + 1)}) begin
        errors++;
        $display("FAIL hold_lane%0d got mw=%b adr=%h data=%h want 1 %h %h", k, MemWrite, DataAdr,
                 WriteData, 32'h200 + 32'(4 * k), 32'h11 * 32'(k + 1));
      end
      tick();
    end
    checks++;
    if ({MemWrite, done} !== 2'b01) begin
      errors++;
      $display("FAIL hold_done got mw=%b done=%b want 0 1", MemWrite, done);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    load(32'h40, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11);
    start = 1'b1; mem_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy, done);
    end
    load(32'h80, 32'd21, 32'd22, 32'd23, 32'd24, 32'd25);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({MemWrite, busy, DataAdr, WriteData} !== {1'b1, 1'b1, 32'h80, 32'd21}) begin
      errors++;
      $display("FAIL b2b_restart got mw=%b busy=%b adr=%h data=%h want 1 1 00000080 00000015",
               MemWrite, busy, DataAdr, WriteData);
    end
    for (int k = 0; k < 7; k++) tick();
  endtask

`ifdef VSTORE_LANE_MASK_EN
  task automatic test_mask();
    logic [31:0] exp_adr [3];
    exp_adr = '{32'h0, 32'h8, 32'h10};
    load(32'h0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    lane_mask = 5'b10101; start = 1'b1; mem_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({MemWrite, DataAdr, WriteData} !== {1'b1, exp_adr[k], 32'(2 * k + 1)}) begin
        errors++;
        $display("FAIL mask_write%0d got mw=%b adr=%h data=%h want 1 %h %h",
                 k, MemWrite, DataAdr, WriteData, exp_adr[k], 32'(2 * k + 1));
      end
      tick();
    end
    checks++;
    if ({MemWrite, done} !== 2'b01) begin
      errors++;
      $display("FAIL mask_done got mw=%b done=%b want 0 1", MemWrite, done);
    end
    tick();
    lane_mask = 5'b00000; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({MemWrite, busy, done} !== 3'b011) begin
      errors++;
      $display("FAIL mask_zero got mw=%b busy=%b done=%b want 0 1 1", MemWrite, busy, done);
    end
    tick();
    checks++;
    if ({MemWrite, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL mask_zero_idle got mw=%b busy=%b done=%b want 0 0 0", MemWrite, busy, done);
    end
    lane_mask = 5'b11111;
  endtask
`endif

  initial begin
`ifdef VSTORE_LANE_MASK_EN
    lane_mask = 5'b11111;
`endif
    test_reset();
`ifdef VSTORE_LANE_MASK_EN
    test_mask();
`else
    test_basic();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
